serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor that processes two `WIDTH`-bit operands one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. Operands are accepted and results returned through valid/ready handshakes, so the block trades latency for area. It is the sequential, handshaked successor to the team's combinational half/full adder cells and feeds arithmetic datapaths where area matters more than throughput.

---
 rtl/serial_adder_if.sv | 28 ++
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder/subtractor.
// master drives operands and accepts results; slave is the adder itself.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             done_valid;
    logic             done_ready;
    logic             busy;

    modport master (
        output start_valid, a, b, cin, sub, done_ready,
        input  start_ready, sum, cout, ovf, done_valid, busy
    );

    modport slave (
        input  start_valid, a, b, cin, sub, done_ready,
        output start_ready, sum, cout, ovf, done_valid, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus carry flop, LSB first.
// Latency: WIDTH cycles from operand acceptance to done_valid.
// Backpressure: result held in DONE until done_ready; operands only taken in IDLE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave io
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             s_bit;
    logic             c_next;

    always_comb begin
        s_bit  = sa_q[0] ^ sb_q[0] ^ c_q;
        c_next = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        r_d     = r_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (io.start_valid) begin
                    sa_d    = io.a;
                    // Subtraction is A + ~B + 1: invert B here, force carry-in to 1
                    sb_d    = io.b ^ {WIDTH{io.sub}};
                    c_d     = io.sub ? 1'b1 : io.cin;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                r_d   = {s_bit, r_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = c_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // c_q here is the carry into the MSB
                    sum_d   = {s_bit, r_q[WIDTH-1:1]};
                    cout_d  = c_next;
                    ovf_d   = c_q ^ c_next;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (io.done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            r_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            r_q     <= r_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign io.start_ready = (state_q == S_IDLE);
    assign io.done_valid  = (state_q == S_DONE);
    assign io.busy        = busy_q;
    assign io.sum         = sum_q;
    assign io.cout        = cout_q;
    assign io.ovf         = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vectors, random
// operations against an arithmetic reference, backpressure, reset and throughput.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_adder_if #(.WIDTH(W)) io ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .io(io));

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed views
    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input logic sub,
                                      output logic [W-1:0] s, output logic co, output logic ov);
        int ua, ub, sa, sb, ci, full, sres;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = cin ? 1 : 0;
        if (!sub) begin
            full = ua + ub + ci;
            sres = sa + sb + ci;
        end else begin
            full = ua - ub + (1 << W);
            sres = sa - sb;
        end
        s  = W'(full);
        co = (full >= (1 << W));
        ov = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
    endfunction

    // Full handshake: returns results, edges from acceptance to done_valid, timeout flag
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, output logic [W-1:0] s, output logic co,
                          output logic ov, output int lat, output bit to);
        bit acc;
        to = 1'b0;
        lat = 0;
        io.a = a; io.b = b; io.cin = cin; io.sub = sub;
        io.start_valid = 1'b1;
        io.done_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            acc = io.start_ready;
            @(posedge clk); #1;
            if (acc) break;
            if (i == 19) to = 1'b1;
        end
        io.start_valid = 1'b0;
        while (!io.done_valid && !to) begin
            @(posedge clk); #1;
            lat++;
            if (lat > 50) to = 1'b1;
        end
        s = io.sum; co = io.cout; ov = io.ovf;
        io.done_ready = 1'b1;
        @(posedge clk); #1;
        io.done_ready = 1'b0;
    endtask

    task automatic test_reset();
        io.start_valid = 1'b0; io.done_ready = 1'b0;
        io.a = '0; io.b = '0; io.cin = 1'b0; io.sub = 1'b0;
        rst_n = 1'b0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({io.start_ready, io.done_valid, io.busy, io.sum, io.cout, io.ovf} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b dv=%b busy=%b sum=%h cout=%b ovf=%b, expected 1 0 0 00 0 0",
                     io.start_ready, io.done_valid, io.busy, io.sum, io.cout, io.ovf);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
        logic [W-1:0] vb[4] = '{8'h3C, 8'h01, 8'h20, 8'h01};
        logic         vc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic         vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] es[4] = '{8'h96, 8'h01, 8'hF0, 8'h7F};
        logic         eco[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         eov[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] s; logic co, ov; int lat; bit to;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], vs[i], s, co, ov, lat, to);
            checks++;
            if (to || lat != W) begin
                errors++;
                $display("FAIL directed%0d latency: got %0d (timeout=%0b), expected %0d", i, lat, to, W);
            end
            checks++;
            if ({s, co, ov} !== {es[i], eco[i], eov[i]}) begin
                errors++;
                $display("FAIL directed%0d result: sum=%h cout=%b ovf=%b, expected %h %b %b",
                         i, s, co, ov, es[i], eco[i], eov[i]);
            end
            checks++;
            if (io.start_ready !== 1'b1 || io.done_valid !== 1'b0 || io.busy !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d post-handshake: rdy=%b dv=%b busy=%b, expected 1 0 0",
                         i, io.start_ready, io.done_valid, io.busy);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s, es; logic cin, sub, co, ov, eco, eov; int lat; bit to;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            ref_model(a, b, cin, sub, es, eco, eov);
            run_op(a, b, cin, sub, s, co, ov, lat, to);
            checks++;
            if (to || lat != W || {s, co, ov} !== {es, eco, eov}) begin
                errors++;
                $display("FAIL random%0d a=%h b=%h cin=%b sub=%b: sum=%h cout=%b ovf=%b lat=%0d, expected %h %b %b lat=%0d",
                         i, a, b, cin, sub, s, co, ov, lat, es, eco, eov, W);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s, es; logic co, ov, eco, eov; int lat;
        io.a = 8'h12; io.b = 8'h34; io.cin = 1'b1; io.sub = 1'b0;
        io.start_valid = 1'b1; io.done_ready = 1'b0;
        @(posedge clk); #1;
        io.start_valid = 1'b0;
        for (int i = 0; i < 50 && !io.done_valid; i++) begin
            @(posedge clk); #1;
        end
        ref_model(8'h12, 8'h34, 1'b1, 1'b0, es, eco, eov);
        io.a = 8'h77; io.b = 8'h11; io.cin = 1'b0; io.sub = 1'b1;
        io.start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({io.done_valid, io.start_ready, io.busy, io.sum, io.cout, io.ovf} !== {1'b1, 1'b0, 1'b1, es, eco, eov}) begin
                errors++;
                $display("FAIL bp_hold%0d: dv=%b rdy=%b busy=%b sum=%h cout=%b ovf=%b, expected 1 0 1 %h %b %b",
                         i, io.done_valid, io.start_ready, io.busy, io.sum, io.cout, io.ovf, es, eco, eov);
            end
            @(posedge clk); #1;
        end
        io.done_ready = 1'b1;
        @(posedge clk); #1;
        io.done_ready = 1'b0;
        checks++;
        if (io.start_ready !== 1'b1 || io.done_valid !== 1'b0 || io.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: rdy=%b dv=%b busy=%b, expected 1 0 0", io.start_ready, io.done_valid, io.busy);
        end
        @(posedge clk); #1;
        io.start_valid = 1'b0;
        lat = 0;
        while (!io.done_valid && lat <= 50) begin
            @(posedge clk); #1;
            lat++;
        end
        ref_model(8'h77, 8'h11, 1'b0, 1'b1, es, eco, eov);
        s = io.sum; co = io.cout; ov = io.ovf;
        checks++;
        if (lat != W || {s, co, ov} !== {es, eco, eov}) begin
            errors++;
            $display("FAIL bp_next: sum=%h cout=%b ovf=%b lat=%0d, expected %h %b %b lat=%0d",
                     s, co, ov, lat, es, eco, eov, W);
        end
        io.done_ready = 1'b1;
        @(posedge clk); #1;
        io.done_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s; logic co, ov; int lat; bit to;
        io.a = 8'hAB; io.b = 8'hCD; io.cin = 1'b1; io.sub = 1'b0;
        io.start_valid = 1'b1;
        @(posedge clk); #1;
        io.start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({io.start_ready, io.done_valid, io.busy, io.sum, io.cout, io.ovf} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_run: rdy=%b dv=%b busy=%b sum=%h cout=%b ovf=%b, expected 1 0 0 00 0 0",
                     io.start_ready, io.done_valid, io.busy, io.sum, io.cout, io.ovf);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h01, 8'h02, 1'b0, 1'b0, s, co, ov, lat, to);
        checks++;
        if (to || lat != W || {s, co, ov} !== {8'h03, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL after_reset_op: sum=%h cout=%b ovf=%b lat=%0d, expected 03 0 0 lat=%0d", s, co, ov, lat, W);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_s[$];
        logic         exp_c[$];
        logic         exp_o[$];
        logic [W-1:0] es, s; logic eco, eov, co, ov;
        int  edge_n = 0, last_acc = -1, nacc = 0, ndone = 0;
        bit  acc, dn;
        io.a = W'($urandom); io.b = W'($urandom); io.cin = 1'($urandom); io.sub = 1'($urandom);
        io.start_valid = 1'b1; io.done_ready = 1'b1;
        while (ndone < 4 && edge_n < 200) begin
            acc = io.start_ready && io.start_valid;
            dn = io.done_valid;
            s = io.sum; co = io.cout; ov = io.ovf;
            if (acc) begin
                ref_model(io.a, io.b, io.cin, io.sub, es, eco, eov);
                exp_s.push_back(es); exp_c.push_back(eco); exp_o.push_back(eov);
            end
            @(posedge clk); #1;
            edge_n++;
            if (dn && exp_s.size() > 0) begin
                es = exp_s.pop_front(); eco = exp_c.pop_front(); eov = exp_o.pop_front();
                checks++;
                if ({s, co, ov} !== {es, eco, eov}) begin
                    errors++;
                    $display("FAIL b2b_result%0d: sum=%h cout=%b ovf=%b, expected %h %b %b", ndone, s, co, ov, es, eco, eov);
                end
                ndone++;
            end
            if (acc) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (edge_n - last_acc != W + 2) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d cycles, expected %0d", edge_n - last_acc, W + 2);
                    end
                end
                last_acc = edge_n;
                nacc++;
                io.a = W'($urandom); io.b = W'($urandom); io.cin = 1'($urandom); io.sub = 1'($urandom);
                if (nacc >= 4) io.start_valid = 1'b0;
            end
        end
        io.start_valid = 1'b0; io.done_ready = 1'b0;
        checks++;
        if (ndone != 4) begin
            errors++;
            $display("FAIL b2b_timeout: %0d results seen, expected 4", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
